// File: rtl/img2col_sched.sv
// img2col_sched: im2col address sequencer for a square IMG_SIZE x IMG_SIZE image buffer.
// Walks a k x k kernel at stride 1 or 2. Elements are row-major within each window, and
// windows are row-major over the output map. Emits one flat pixel address per
// valid/ready beat.
//
// Optional feature macro: IMG2COL_PAD_EN. When defined, it adds pad_en/o_pad and a
// 1-pixel zero border, so the effective image becomes (IMG_SIZE+2) square.
//
// Ports:
//   clk          rising-edge clock
//   nrst         synchronous, active-high reset
//   start        begin a pass (sampled only when idle)
//   k            kernel size, legal 1..min(5,IMG_SIZE)
//   stride       0 = stride 1, 1 = stride 2
//   pad_en       (IMG2COL_PAD_EN only) enable zero border, latched at start
//   busy         high while a pass is streaming
//   done         one-cycle pulse after the final beat handshake
//   cfg_err      one-cycle pulse when start is sampled with an illegal k
//   o_valid      address beat valid
//   o_ready      downstream accepts beat
//   o_addr       flat pixel address row*IMG_SIZE+col
//   o_win        window index orow*N+ocol
//   o_last_elem  final element of current window
//   o_last_win   final beat of the pass
//   o_pad        (IMG2COL_PAD_EN only) beat lies in the zero border
module img2col_sched #(
    parameter int unsigned IMG_SIZE = 5,
    parameter int unsigned ADDR_W   = $clog2(IMG_SIZE * IMG_SIZE),
    parameter int unsigned WIN_W    = $clog2(IMG_SIZE * IMG_SIZE)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [2:0]        k,
    input  logic              stride,
`ifdef IMG2COL_PAD_EN
    input  logic              pad_en,
    output logic              o_pad,
`endif
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [WIN_W-1:0]  o_win,
    output logic              o_last_elem,
    output logic              o_last_win
);

    localparam int unsigned CW   = $clog2(IMG_SIZE + 2) + 1;  // coordinate/counter width
    localparam int unsigned PW   = ADDR_W + CW;                // address product width
    localparam int unsigned WP   = WIN_W + CW;                 // window product width
    localparam logic [2:0]  KMax = (IMG_SIZE < 5) ? 3'(IMG_SIZE) : 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d, kr_q, kr_d, kc_q, kc_d;
    logic              str_q, str_d;
    logic [CW-1:0]     nm1_q, nm1_d, orow_q, orow_d, ocol_q, ocol_d;
    logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic              valid_q, valid_d, le_q, le_d, lw_q, lw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CW-1:0]     row, col, ext;
`ifdef IMG2COL_PAD_EN
    logic              pad_q, pad_d, opad_q, opad_d;
`endif

    function automatic logic [ADDR_W-1:0] flat_addr(input logic [CW-1:0] r,
                                                    input logic [CW-1:0] c);
        return ADDR_W'(PW'(r) * PW'(IMG_SIZE) + PW'(c));
    endfunction

    // Next-state: FSM plus the nested kc -> kr -> ocol -> orow counter chain.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        str_d     = str_q;
        nm1_d     = nm1_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        cfg_err_d = 1'b0;
`ifdef IMG2COL_PAD_EN
        pad_d     = pad_q;
        ext       = pad_en ? CW'(IMG_SIZE + 2) : CW'(IMG_SIZE);
`else
        ext       = CW'(IMG_SIZE);
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (k != 3'd0 && k <= KMax) begin
                        k_d     = k;
                        str_d   = stride;
                        // N-1 = (ext-k)/(stride+1); the divide is a shift
                        nm1_d   = (ext - CW'(k)) >> stride;
                        kr_d    = '0;
                        kc_d    = '0;
                        orow_d  = '0;
                        ocol_d  = '0;
`ifdef IMG2COL_PAD_EN
                        pad_d   = pad_en;
`endif
                        state_d = StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (valid_q && o_ready) begin
                    if (lw_q) begin
                        state_d = StDone;
                    end else if (kc_q != k_q - 3'd1) begin
                        kc_d = kc_q + 3'd1;
                    end else begin
                        kc_d = '0;
                        if (kr_q != k_q - 3'd1) begin
                            kr_d = kr_q + 3'd1;
                        end else begin
                            kr_d = '0;
                            if (ocol_q != nm1_q) begin
                                ocol_d = ocol_q + CW'(1);
                            end else begin
                                ocol_d = '0;
                                orow_d = orow_q + CW'(1);
                            end
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are precomputed from next-state values so every output is a flop.
    always_comb begin
        valid_d = (state_d == StRun);
        busy_d  = valid_d;
        done_d  = (state_d == StDone);
        addr_d  = '0;
        win_d   = '0;
        le_d    = 1'b0;
        lw_d    = 1'b0;
        row     = (str_d ? {orow_d[CW-2:0], 1'b0} : orow_d) + CW'(kr_d);
        col     = (str_d ? {ocol_d[CW-2:0], 1'b0} : ocol_d) + CW'(kc_d);
`ifdef IMG2COL_PAD_EN
        opad_d  = 1'b0;
`endif
        if (valid_d) begin
            le_d  = (kr_d == k_d - 3'd1) && (kc_d == k_d - 3'd1);
            lw_d  = le_d && (orow_d == nm1_d) && (ocol_d == nm1_d);
            win_d = WIN_W'(WP'(orow_d) * (WP'(nm1_d) + WP'(1)) + WP'(ocol_d));
`ifdef IMG2COL_PAD_EN
            if (pad_d) begin
                if (row == '0 || col == '0 || row > CW'(IMG_SIZE) || col > CW'(IMG_SIZE)) begin
                    opad_d = 1'b1;
                end else begin
                    addr_d = flat_addr(row - CW'(1), col - CW'(1));
                end
            end else begin
                addr_d = flat_addr(row, col);
            end
`else
            addr_d = flat_addr(row, col);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            str_q     <= 1'b0;
            nm1_q     <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            valid_q   <= 1'b0;
            le_q      <= 1'b0;
            lw_q      <= 1'b0;
            addr_q    <= '0;
            win_q     <= '0;
`ifdef IMG2COL_PAD_EN
            pad_q     <= 1'b0;
            opad_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            str_q     <= str_d;
            nm1_q     <= nm1_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            valid_q   <= valid_d;
            le_q      <= le_d;
            lw_q      <= lw_d;
            addr_q    <= addr_d;
            win_q     <= win_d;
`ifdef IMG2COL_PAD_EN
            pad_q     <= pad_d;
            opad_q    <= opad_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign o_valid     = valid_q;
    assign o_addr      = addr_q;
    assign o_win       = win_q;
    assign o_last_elem = le_q;
    assign o_last_win  = lw_q;
`ifdef IMG2COL_PAD_EN
    assign o_pad       = opad_q;
`endif

endmodule

// File: tb/tb_img2col_sched.sv
module tb_img2col_sched;
    localparam int IMG = 5;

    logic       clk = 1'b0;
    logic       nrst, start, stride, o_ready;
    logic [2:0] k;
    logic       busy, done, cfg_err, o_valid, o_last_elem, o_last_win;
    logic [4:0] o_addr, o_win;
`ifdef IMG2COL_PAD_EN
    logic       o_pad;
`endif

    always #5 clk = ~clk;

    img2col_sched #(.IMG_SIZE(IMG)) dut (
        .clk(clk), .nrst(nrst), .start(start), .k(k), .stride(stride),
`ifdef IMG2COL_PAD_EN
        .pad_en(1'b0), .o_pad(o_pad),
`endif
        .busy(busy), .done(done), .cfg_err(cfg_err), .o_valid(o_valid), .o_ready(o_ready),
        .o_addr(o_addr), .o_win(o_win), .o_last_elem(o_last_elem), .o_last_win(o_last_win)
    );

    int checks = 0;
    int passed = 0;
    int ga[$], gw[$], gle[$], glw[$];
    int ea[$], ew[$], ele[$], elw[$];
    int last_beat_cyc, done_cyc, done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [2:0] kk, input logic st);
        start  = 1'b1;
        k      = kk;
        stride = st;
        tick();
        start  = 1'b0;
    endtask

    task automatic build_exp(input int kk, input int st);
        int s, n;
        s = st + 1;
        n = (IMG - kk) / s + 1;
        ea.delete(); ew.delete(); ele.delete(); elw.delete();
        for (int orow = 0; orow < n; orow++)
            for (int ocol = 0; ocol < n; ocol++)
                for (int kr = 0; kr < kk; kr++)
                    for (int kc = 0; kc < kk; kc++) begin
                        ea.push_back((orow * s + kr) * IMG + ocol * s + kc);
                        ew.push_back(orow * n + ocol);
                        ele.push_back((kr == kk - 1 && kc == kk - 1) ? 1 : 0);
                        elw.push_back((kr == kk - 1 && kc == kk - 1 &&
                                       orow == n - 1 && ocol == n - 1) ? 1 : 0);
                    end
    endtask

    // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1
    task automatic collect(input int rmode, input int max_beats, input bit mid_start);
        int cyc;
        logic [4:0] pa, pw;
        logic ple, plw, pv, pr;
        ga.delete(); gw.delete(); gle.delete(); glw.delete();
        done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
        pv = 1'b0; pr = 1'b1; pa = '0; pw = '0; ple = 1'b0; plw = 1'b0;
        cyc = 0;
        while (cyc < 600 && done_cnt == 0 && ga.size() < max_beats) begin
            o_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start   = mid_start && (cyc == 6);
            if (mid_start && cyc == 6) begin
                k      = 3'd5;
                stride = 1'b1;
            end
            if (pv && !pr) begin
                check($sformatf("stall valid c%0d", cyc), o_valid, 1);
                check($sformatf("stall addr c%0d", cyc), o_addr, pa);
                check($sformatf("stall win c%0d", cyc), o_win, pw);
                check($sformatf("stall le c%0d", cyc), o_last_elem, ple);
                check($sformatf("stall lw c%0d", cyc), o_last_win, plw);
            end
            if (o_valid && o_ready) begin
                ga.push_back(int'(o_addr));
                gw.push_back(int'(o_win));
                gle.push_back(int'(o_last_elem));
                glw.push_back(int'(o_last_win));
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            pv = o_valid; pr = o_ready; pa = o_addr; pw = o_win;
            ple = o_last_elem; plw = o_last_win;
            tick();
            cyc++;
        end
        start   = 1'b0;
        o_ready = 1'b1;
        if (max_beats > 1000) begin
            check("pass ended with done", done_cnt, 1);
            check("done one cycle", done, 0);
        end
    endtask

    task automatic compare_seq(input string tag);
        check({tag, " beats"}, ga.size(), ea.size());
        for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), ga[i], ea[i]);
            check($sformatf("%s win[%0d]", tag, i), gw[i], ew[i]);
            check($sformatf("%s le[%0d]", tag, i), gle[i], ele[i]);
            check($sformatf("%s lw[%0d]", tag, i), glw[i], elw[i]);
        end
        check({tag, " done latency"}, done_cyc, last_beat_cyc + 1);
    endtask

    initial begin
        int w0[9];
        int w8[9];
        int sum;
        w0 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        w8 = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

        nrst = 1'b1; start = 1'b0; k = 3'd0; stride = 1'b0; o_ready = 1'b0;
        tick(); tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cfg_err", cfg_err, 0);
        check("rst valid", o_valid, 0);
        check("rst addr", o_addr, 0);
        check("rst win", o_win, 0);
        check("rst le", o_last_elem, 0);
        check("rst lw", o_last_win, 0);
        nrst = 1'b0;
        tick();

        // k=3 stride 1: 9 windows
        start_pass(3'd3, 1'b0);
        check("s1 busy", busy, 1);
        check("s1 first valid", o_valid, 1);
        check("s1 first addr", o_addr, 0);
        collect(0, 100000, 1'b0);
        build_exp(3, 0);
        compare_seq("s1");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("s1 w0[%0d]", i), ga[i], w0[i]);
            check($sformatf("s1 w8[%0d]", i), ga[72 + i], w8[i]);
        end
        check("s1 lw on beat 81", glw[80], 1);
        check("s1 idle busy", busy, 0);

        // k=3 stride 2: 4 windows
        start_pass(3'd3, 1'b1);
        collect(0, 100000, 1'b0);
        build_exp(3, 1);
        compare_seq("s2");
        check("s2 beats", ga.size(), 36);
        check("s2 win1 first", ga[9], 2);
        check("s2 win2 first", ga[18], 10);
        check("s2 win3 last", ga[35], 24);

        // k=5: single window covering the image
        start_pass(3'd5, 1'b0);
        collect(0, 100000, 1'b0);
        build_exp(5, 0);
        compare_seq("s3k5");
        check("s3k5 last addr", ga[24], 24);
        check("s3k5 last le", gle[24], 1);
        check("s3k5 last lw", glw[24], 1);

        // k=1: every beat is the last element of its window
        start_pass(3'd1, 1'b0);
        collect(0, 100000, 1'b0);
        build_exp(1, 0);
        compare_seq("s3k1");
        sum = 0;
        foreach (gle[i]) sum += gle[i];
        check("s3k1 le count", sum, 25);

        // illegal kernel sizes
        start_pass(3'd0, 1'b0);
        check("k0 cfg_err", cfg_err, 1);
        check("k0 busy", busy, 0);
        check("k0 valid", o_valid, 0);
        tick();
        check("k0 cfg_err pulse", cfg_err, 0);
        check("k0 still idle", o_valid, 0);
        start_pass(3'd6, 1'b0);
        check("k6 cfg_err", cfg_err, 1);
        check("k6 busy", busy, 0);
        check("k6 valid", o_valid, 0);
        tick();
        check("k6 cfg_err pulse", cfg_err, 0);
        check("k6 still idle", busy, 0);

        // backpressure plus an ignored mid-pass start with different config
        start_pass(3'd3, 1'b0);
        collect(1, 100000, 1'b1);
        build_exp(3, 0);
        compare_seq("s5");

        // reset mid-pass after 40 beats
        start_pass(3'd3, 1'b0);
        collect(0, 40, 1'b0);
        check("s6 beats before rst", ga.size(), 40);
        nrst = 1'b1;
        tick();
        check("s6 rst busy", busy, 0);
        check("s6 rst valid", o_valid, 0);
        check("s6 rst done", done, 0);
        check("s6 rst addr", o_addr, 0);
        check("s6 rst win", o_win, 0);
        check("s6 rst le", o_last_elem, 0);
        nrst = 1'b0;
        tick();
        check("s6 no done 1", done, 0);
        tick();
        check("s6 no done 2", done, 0);
        check("s6 idle valid", o_valid, 0);
        start_pass(3'd3, 1'b0);
        check("s6 restart addr", o_addr, 0);
        check("s6 restart valid", o_valid, 1);
        check("s6 restart win", o_win, 0);
        collect(0, 100000, 1'b0);
        build_exp(3, 0);
        compare_seq("s6");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
